// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the seven-segment frame output stage
package seg7_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE,
        ST_COMMIT
    } state_t;

    localparam logic [7:0] SEG7_BLANK = 8'hFF;
    localparam logic [7:0] SEG7_SAT   = 8'h99;
    localparam logic [3:0] BCD_ADD3   = 4'd3;

    // Double-dabble correction: a digit of 5 or more would exceed 9 after doubling
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + BCD_ADD3 : nib;
    endfunction

endpackage

// File: rtl/seg7_frame_out_bin2bcd8.sv
// rtl/seg7_frame_out_bin2bcd8.sv - serial 8-bit binary to BCD converter, one bit per step
module bin2bcd8
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] din,
    output logic [7:0] result,
    output logic       hund_nz
);

    // {hundreds, tens, ones, remaining binary bits}
    logic [19:0] dd;
    logic [19:0] dd_adj;

    // Correct every BCD digit ahead of the shift
    always_comb begin
        dd_adj = {bcd_adjust(dd[19:16]), bcd_adjust(dd[15:12]),
                  bcd_adjust(dd[11:8]), dd[7:0]};
    end

    // Load a fresh value or advance the conversion by one bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dd <= '0;
        end else if (load) begin
            dd <= {12'd0, din};
        end else if (step) begin
            dd <= {dd_adj[18:0], 1'b0};
        end
    end

    assign result  = dd[15:8];
    assign hund_nz = |dd[19:16];

endmodule

// File: rtl/seg7_frame_out.sv
// rtl/seg7_frame_out.sv - snapshots game values, converts them to BCD and commits whole display frames
module seg7_frame_out
    import seg7_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int LED_W     = 10,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH*8-1:0] ch_val,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic [LED_W-1:0]    led_in,
    input  logic [LED_W-1:0]    led_blink,
    input  logic                update,
    output logic [NUM_CH*8-1:0] seg7_num,
    output logic [NUM_CH-1:0]   ch_ovf,
    output logic [LED_W-1:0]    led,
    output logic                busy,
    output logic                frame_done
);

    localparam int IW = $clog2(NUM_CH) + 1;
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

    state_t              state;
    logic [IW-1:0]       ch_idx;
    logic [2:0]          bit_cnt;
    logic                pending;

    logic [NUM_CH*8-1:0] val_sh;
    logic [NUM_CH-1:0]   en_sh;
    logic [LED_W-1:0]    led_sh;
    logic [LED_W-1:0]    blink_sh;
    logic [NUM_CH*8-1:0] frame_sh;
    logic [NUM_CH-1:0]   ovf_sh;
    logic [LED_W-1:0]    led_commit;
    logic [LED_W-1:0]    blink_commit;

    logic [CW-1:0]       blink_cnt;
    logic                phase;

    logic [7:0]          dd_din;
    logic [7:0]          dd_result;
    logic                dd_hund_nz;
    logic                cur_en;
    logic [7:0]          store_byte;
    logic                store_ovf;

    // Select the shadowed value and enable for the channel being converted
    always_comb begin
        dd_din = '0;
        cur_en = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == IW'(i)) begin
                dd_din = val_sh[i*8 +: 8];
                cur_en = en_sh[i];
            end
        end
    end

    // Blank disabled channels, saturate anything above 99
    always_comb begin
        store_byte = dd_result;
        store_ovf  = 1'b0;
        if (!cur_en) begin
            store_byte = SEG7_BLANK;
        end else if (dd_hund_nz) begin
            store_byte = SEG7_SAT;
            store_ovf  = 1'b1;
        end
    end

    bin2bcd8 u_bin2bcd8 (
        .clk     (clk),
        .rst     (rst),
        .load    (state == ST_LOAD),
        .step    (state == ST_SHIFT),
        .din     (dd_din),
        .result  (dd_result),
        .hund_nz (dd_hund_nz)
    );

    // Frame sequencer: snapshot, per-channel conversion, atomic commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ch_idx       <= '0;
            bit_cnt      <= '0;
            pending      <= 1'b0;
            val_sh       <= '0;
            en_sh        <= '0;
            led_sh       <= '0;
            blink_sh     <= '0;
            frame_sh     <= {NUM_CH{SEG7_BLANK}};
            ovf_sh       <= '0;
            seg7_num     <= {NUM_CH{SEG7_BLANK}};
            ch_ovf       <= '0;
            led_commit   <= '0;
            blink_commit <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Requests during a conversion collapse into one follow-up frame
            if (state != ST_IDLE && update) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (update || pending) begin
                        val_sh   <= ch_val;
                        en_sh    <= ch_en;
                        led_sh   <= led_in;
                        blink_sh <= led_blink;
                        pending  <= 1'b0;
                        ch_idx   <= '0;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt == 3'd7) begin
                        state <= ST_STORE;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_STORE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_idx == IW'(i)) begin
                            frame_sh[i*8 +: 8] <= store_byte;
                            ovf_sh[i]          <= store_ovf;
                        end
                    end
                    if (ch_idx == LAST_IDX) begin
                        state <= ST_COMMIT;
                    end else begin
                        ch_idx <= ch_idx + IW'(1);
                        state  <= ST_LOAD;
                    end
                end
                ST_COMMIT: begin
                    seg7_num     <= frame_sh;
                    ch_ovf       <= ovf_sh;
                    led_commit   <= led_sh;
                    blink_commit <= blink_sh;
                    frame_done   <= 1'b1;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running blink timebase, independent of frame activity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == CNT_MAX) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    assign led = led_commit & ~(blink_commit & {LED_W{phase}});

endmodule

// File: tb/tb_seg7_frame_out.sv
// tb/tb_seg7_frame_out.sv - self-checking bench for seg7_frame_out
module tb_seg7_frame_out;

    localparam int NCH  = 4;
    localparam int LW   = 10;
    localparam int BDIV = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH*8-1:0] ch_val;
    logic [NCH-1:0]  ch_en;
    logic [LW-1:0]   led_in;
    logic [LW-1:0]   led_blink;
    logic            update;
    logic [NCH*8-1:0] seg7_num;
    logic [NCH-1:0]  ch_ovf;
    logic [LW-1:0]   led;
    logic            busy;
    logic            frame_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] model_seg;
    logic [3:0]  model_ovf;
    logic [9:0]  model_li;
    logic [9:0]  model_lb;

    seg7_frame_out #(.NUM_CH(NCH), .LED_W(LW), .BLINK_DIV(BDIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_val     (ch_val),
        .ch_en      (ch_en),
        .led_in     (led_in),
        .led_blink  (led_blink),
        .update     (update),
        .seg7_num   (seg7_num),
        .ch_ovf     (ch_ovf),
        .led        (led),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Cycles since reset release, for the blink phase reference
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [31:0] v;
        logic [3:0]  en;
        logic [31:0] seg;
        logic [3:0]  ovf;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] exp_led(input logic [9:0] li, input logic [9:0] lb);
        logic ph;
        ph = ((cyc / BDIV) % 2) == 1;
        return li & ~(lb & {10{ph}});
    endfunction

    // Reference: decimal display rules applied per channel
    task automatic model_frame(input logic [31:0] v, input logic [3:0] en,
                               output logic [31:0] seg, output logic [3:0] ovf);
        int b;
        for (int i = 0; i < NCH; i++) begin
            b = int'(v[i*8 +: 8]);
            ovf[i] = 1'b0;
            if (!en[i]) begin
                seg[i*8 +: 8] = 8'hFF;
            end else if (b > 99) begin
                seg[i*8 +: 8] = 8'h99;
                ovf[i] = 1'b1;
            end else begin
                seg[i*8 +: 8] = {4'(b / 10), 4'(b % 10)};
            end
        end
    endtask

    task automatic run_frame(input logic [31:0] v, input logic [3:0] en,
                             input logic [9:0] li, input logic [9:0] lb,
                             input logic [31:0] eseg, input logic [3:0] eovf);
        int n;
        ch_val = v; ch_en = en; led_in = li; led_blink = lb; update = 1'b1;
        tick();
        update = 1'b0;
        ch_val = $urandom; ch_en = 4'($urandom); led_in = 10'($urandom); led_blink = 10'($urandom);
        check("busy_start", busy, 1);
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            if (n == 20) begin
                check("hold_seg", seg7_num, model_seg);
                check("hold_led", led, exp_led(model_li, model_lb));
            end
            tick();
            n++;
        end
        check("latency", n, 41);
        check("seg7", seg7_num, eseg);
        check("ovf", ch_ovf, eovf);
        check("led", led, exp_led(li, lb));
        model_seg = eseg; model_ovf = eovf; model_li = li; model_lb = lb;
        tick();
        check("done_pulse", frame_done, 0);
        check("busy_end", busy, 0);
    endtask

    initial begin
        logic [31:0] rv, a_v, c_v, eseg;
        logic [3:0]  ren, eovf;
        int r, frames, t1, t2, seen;

        tbl[0] = '{32'h07_2A_63_00, 4'hF, 32'h0742_9900, 4'b0000};
        tbl[1] = '{32'hC8_05_64_FF, 4'b1011, 32'h99FF_9999, 4'b1011};
        tbl[2] = '{32'h63_64_09_0A, 4'b0110, 32'hFF99_09FF, 4'b0100};
        tbl[3] = '{32'h01_32_62_40, 4'hF, 32'h0150_9864, 4'b0000};
        tbl[4] = '{32'h00_00_00_00, 4'h0, 32'hFFFF_FFFF, 4'b0000};

        rst = 1'b1; update = 1'b0; ch_val = '0; ch_en = '0; led_in = '0; led_blink = '0;
        model_seg = 32'hFFFF_FFFF; model_ovf = '0; model_li = '0; model_lb = '0;
        tick(); tick(); tick();
        check("rst_seg", seg7_num, 32'hFFFF_FFFF);
        check("rst_ovf", ch_ovf, 0);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        rst = 1'b0;
        ch_val = 32'h1234_5678; ch_en = 4'hF; led_in = 10'h3FF;
        for (int i = 0; i < 5; i++) tick();
        check("idle_seg", seg7_num, 32'hFFFF_FFFF);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++)
            run_frame(tbl[i].v, tbl[i].en, 10'($urandom), 10'h000, tbl[i].seg, tbl[i].ovf);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NCH; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)      rv[i*8 +: 8] = 8'($urandom_range(0, 99));
                else if (r < 8) rv[i*8 +: 8] = 8'($urandom_range(100, 255));
                else if (r == 8) rv[i*8 +: 8] = 8'd99;
                else            rv[i*8 +: 8] = 8'd100;
            end
            ren = 4'($urandom);
            model_frame(rv, ren, eseg, eovf);
            run_frame(rv, ren, 10'($urandom), 10'($urandom), eseg, eovf);
        end

        // Back-to-back: requests during busy merge into one frame sampled at its start
        a_v = 32'h01_02_03_04; c_v = 32'h11_22_33_44;
        ch_en = 4'hF; led_in = 10'h155; led_blink = 10'h000;
        frames = 0; t1 = -1; t2 = -1;
        for (int c = 0; c < 140; c++) begin
            update = (c == 0 || c == 5 || c == 12);
            if (c == 0)  ch_val = a_v;
            if (c == 3)  ch_val = 32'h05_06_07_08;
            if (c == 20) ch_val = c_v;
            tick();
            if (frame_done === 1'b1) begin
                frames++;
                if (frames == 1) begin
                    t1 = c;
                    model_frame(a_v, 4'hF, eseg, eovf);
                    check("b2b_first", seg7_num, eseg);
                end else if (frames == 2) begin
                    t2 = c;
                    model_frame(c_v, 4'hF, eseg, eovf);
                    check("b2b_second", seg7_num, eseg);
                end
            end
        end
        update = 1'b0;
        check("b2b_frames", frames, 2);
        check("b2b_t1", t1, 41);
        check("b2b_gap", t2 - t1, 42);
        model_frame(c_v, 4'hF, model_seg, model_ovf);
        model_li = 10'h155; model_lb = 10'h000;

        // Blink masking on LED 0 only
        run_frame(32'h00_00_00_00, 4'hF, 10'h3FF, 10'h001, 32'h0000_0000, 4'b0000);
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            check("blink", led, exp_led(10'h3FF, 10'h001));
            if (led[0] == 1'b0) seen++;
        end
        check("blink_dark_cycles", seen, 8);

        // Reset during SHIFT with a pending request
        run_frame(tbl[0].v, tbl[0].en, 10'h2AA, 10'h000, tbl[0].seg, tbl[0].ovf);
        ch_val = 32'h10_20_30_40; update = 1'b1;
        tick();
        update = 1'b0;
        tick(); tick(); tick();
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_seg", seg7_num, 32'hFFFF_FFFF);
        check("arst_ovf", ch_ovf, 0);
        check("arst_led", led, 0);
        check("arst_busy", busy, 0);
        check("arst_done", frame_done, 0);
        tick(); tick();
        rst = 1'b0;
        model_seg = 32'hFFFF_FFFF; model_ovf = '0; model_li = '0; model_lb = '0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (frame_done === 1'b1 || busy === 1'b1) seen++;
        end
        check("pending_dropped", seen, 0);
        run_frame(tbl[3].v, tbl[3].en, 10'h0F0, 10'h000, tbl[3].seg, tbl[3].ovf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
